// File: rtl/two_entry_fifo.sv
// Two-slot registered elastic buffer: ready/valid on the input side, valid/yumi on the output side.
// Storage is always registered; input data never passes straight through to data_o.
module two_entry_fifo #(
  parameter int width_p                 = 32,
  parameter bit allow_enq_deq_on_full_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  output logic               ready_o,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  generate
    if (width_p < 1) begin : g_width_check
      $error("two_entry_fifo: width_p must be >= 1");
    end
  endgenerate

  logic [width_p-1:0] mem_q [2];
  logic [width_p-1:0] mem_d [2];
  logic               wptr_q, wptr_d;
  logic               rptr_q, rptr_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               enq, deq;

  // Handshake: a word moves in when v_i & ready_o, and out when yumi_i while v_o.
  // A yumi_i on an empty buffer is masked so it cannot disturb the pointers.
  assign ready_o = allow_enq_deq_on_full_p ? (~full_q | yumi_i) : ~full_q;
  assign v_o     = ~empty_q;
  assign data_o  = mem_q[rptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & ~empty_q;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (enq) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = ~wptr_q;
    end
    if (deq) begin
      rptr_d = ~rptr_q;
    end
    if (enq && !deq) begin
      empty_d = 1'b0;
      full_d  = (~wptr_q == rptr_q);
    end else if (deq && !enq) begin
      full_d  = 1'b0;
      empty_d = (~rptr_q == wptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage carries no reset; its contents are only observed while v_o is high.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && v_i && !ready_o) begin
      $error("two_entry_fifo: v_i asserted while ready_o=0, write dropped");
    end
    if (reset_n_i && yumi_i && empty_q) begin
      $error("two_entry_fifo: yumi_i asserted while v_o=0, ignored");
    end
  end
`endif

endmodule

// File: tb/tb_two_entry_fifo.sv
// Bench for two_entry_fifo: one instance without and one with the enq-while-full option,
// each compared every cycle against a queue model of a two-deep FIFO.
module tb_two_entry_fifo;

  logic        clk;
  logic        reset_n;
  logic        v0, y0, v1, y1;
  logic [31:0] d0, d1;
  logic        r0, vo0, r1, vo1;
  logic [31:0] do0, do1;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          n_cmp;
  int          n_bad;

  two_entry_fifo #(.width_p(32), .allow_enq_deq_on_full_p(1'b0)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .ready_o(r0), .v_i(v0), .data_i(d0),
    .v_o(vo0), .data_o(do0), .yumi_i(y0)
  );

  two_entry_fifo #(.width_p(32), .allow_enq_deq_on_full_p(1'b1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .ready_o(r1), .v_i(v1), .data_i(d1),
    .v_o(vo1), .data_o(do1), .yumi_i(y1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: ready when fewer than two words are held, or (option) a word leaves this cycle.
  function automatic logic model_ready(input int size, input logic allow, input logic yumi);
    return (size < 2) || (allow && yumi && size > 0);
  endfunction

  task automatic drive(input logic a_v0, input logic [31:0] a_d0, input logic a_y0,
                       input logic a_v1, input logic [31:0] a_d1, input logic a_y1);
    v0 = a_v0; d0 = a_d0; y0 = a_y0;
    v1 = a_v1; d1 = a_d1; y1 = a_y1;
  endtask

  // Compare both DUTs with the model, clock once, then advance the model.
  task automatic tick();
    logic e0, e1, p0, p1;
    #1;
    check_eq("ready0", {31'd0, r0}, {31'd0, model_ready(q0.size(), 1'b0, y0)});
    check_eq("v_o0", {31'd0, vo0}, {31'd0, q0.size() > 0});
    if (q0.size() > 0) check_eq("data_o0", do0, q0[0]);
    check_eq("ready1", {31'd0, r1}, {31'd0, model_ready(q1.size(), 1'b1, y1)});
    check_eq("v_o1", {31'd0, vo1}, {31'd0, q1.size() > 0});
    if (q1.size() > 0) check_eq("data_o1", do1, q1[0]);
    e0 = v0 && model_ready(q0.size(), 1'b0, y0);
    e1 = v1 && model_ready(q1.size(), 1'b1, y1);
    p0 = y0 && q0.size() > 0;
    p1 = y1 && q1.size() > 0;
    @(posedge clk);
    if (!reset_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (p0) void'(q0.pop_front());
      if (e0) q0.push_back(d0);
      if (p1) void'(q1.pop_front());
      if (e1) q1.push_back(d1);
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset held two cycles, then idle.
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("rst_v_o", {31'd0, vo0}, 32'd0);
    check_eq("rst_ready", {31'd0, r0}, 32'd1);

    // Fill with two words, no yumi.
    drive(1, 32'hA5A5A5A5, 0, 0, 0, 0);
    tick();
    drive(1, 32'h5A5A5A5A, 0, 0, 0, 0);
    #1;
    check_eq("fill_first_v", {31'd0, vo0}, 32'd1);
    check_eq("fill_first_data", do0, 32'hA5A5A5A5);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check_eq("fill_full_ready", {31'd0, r0}, 32'd0);

    // Drain.
    drive(0, 0, 1, 0, 0, 0);
    #1;
    check_eq("drain_data0", do0, 32'hA5A5A5A5);
    tick();
    #1;
    check_eq("drain_data1", do0, 32'h5A5A5A5A);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check_eq("drain_empty_v", {31'd0, vo0}, 32'd0);
    check_eq("drain_empty_ready", {31'd0, r0}, 32'd1);

    // Streaming 0..99 with yumi whenever data is held.
    begin
      int got_cnt;
      got_cnt = 0;
      for (int i = 0; i < 101; i++) begin
        drive(i < 100, 32'(i), q0.size() > 0, 0, 0, 0);
        #1;
        if (q0.size() > 0) begin
          check_eq("stream_order", do0, 32'(got_cnt));
          got_cnt++;
        end
        check_eq("stream_not_full", {31'd0, r0}, 32'd1);
        tick();
      end
      check_eq("stream_count", 32'(got_cnt), 32'd100);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Enq-while-full option on dut1.
    drive(0, 0, 0, 1, 32'h1, 0);
    tick();
    drive(0, 0, 0, 1, 32'h2, 0);
    tick();
    drive(0, 0, 0, 1, 32'h3, 1);
    #1;
    check_eq("allow_ready", {31'd0, r1}, 32'd1);
    check_eq("allow_head", do1, 32'h1);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    #1;
    check_eq("allow_count", 32'(q1.size()), 32'd2);
    check_eq("allow_still_full", {31'd0, r1}, 32'd1);
    check_eq("allow_second", do1, 32'h2);
    tick();
    #1;
    check_eq("allow_third", do1, 32'h3);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Reset while both hold two words.
    drive(1, 32'hAA, 0, 1, 32'hBB, 0);
    tick();
    drive(1, 32'hCC, 0, 1, 32'hDD, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("rst_mid_v0", {31'd0, vo0}, 32'd0);
    check_eq("rst_mid_ready0", {31'd0, r0}, 32'd1);
    check_eq("rst_mid_v1", {31'd0, vo1}, 32'd0);
    drive(1, 32'h7, 0, 1, 32'h7, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check_eq("rst_mid_data0", do0, 32'h7);
    check_eq("rst_mid_data1", do1, 32'h7);
    drive(0, 0, 1, 0, 0, 1);
    tick();

    // Randomized legal traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      logic a_y0, a_y1, a_v0, a_v1;
      a_y0 = (q0.size() > 0) && ($urandom_range(0, 2) != 0);
      a_y1 = (q1.size() > 0) && ($urandom_range(0, 2) != 0);
      a_v0 = model_ready(q0.size(), 1'b0, a_y0) && ($urandom_range(0, 2) != 0);
      a_v1 = model_ready(q1.size(), 1'b1, a_y1) && ($urandom_range(0, 2) != 0);
      drive(a_v0, $urandom, a_y0, a_v1, $urandom, a_y1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
